// File: rtl/vga_pixel_engine.sv
// vga_pixel_engine: raster timing generator, framebuffer read port, pixel
// expansion (RGB332 / RGB565 / colour bars) and latency-matched VGA DAC drive.
module vga_pixel_engine #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int DAC_W    = 10,
    parameter int RD_LAT   = 2,
    parameter int ADDR_W   = 19
) (
    input  logic              c25,
    input  logic              Reset,
    input  logic [1:0]        mode,
    input  logic [15:0]       pixel_in,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              frame_start,
    output logic              line_start,
    output logic [DAC_W-1:0]  VGA_R,
    output logic [DAC_W-1:0]  VGA_G,
    output logic [DAC_W-1:0]  VGA_B,
    output logic              VGA_CLK,
    output logic              VGA_BLANK,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_SYNC
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Pipeline tag layout: {mode[1:0], bar[2:0], vs, hs, active}.
    // Reset value is inactive with both syncs high.
    localparam logic [7:0] TAG_RST = 8'b0000_0110;

    // Replicate a w-bit field MSB-first until DAC_W bits are filled.
    function automatic logic [DAC_W-1:0] f_expand(input logic [7:0] fld, input int w);
        logic [DAC_W-1:0] res;
        int               k;
        logic [2:0]       idx;
        res = '0;
        for (int i = 0; i < DAC_W; i++) begin
            k   = w - 1 - (i % w);
            idx = k[2:0];
            res = {res[DAC_W-2:0], fld[idx]};
        end
        return res;
    endfunction

    // Colour-bar index: eight equal-width bars across the visible line.
    function automatic logic [2:0] f_bar(input logic [HW-1:0] h);
        logic [HW-1:0] q;
        q = h / HW'(H_ACTIVE / 8);
        return q[2:0];
    endfunction

    logic              r_run;
    logic [HW-1:0]     r_h;
    logic [VW-1:0]     r_v;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_mode_q;

    logic [HW-1:0]     w_h_nx;
    logic [VW-1:0]     w_v_nx;
    logic              w_wrap;
    logic              w_act_p0;
    logic              w_hs_p0;
    logic              w_vs_p0;
    logic [7:0]        w_tag_p0;
    logic [7:0]        w_tag_pn;
    logic [DAC_W-1:0]  w_r;
    logic [DAC_W-1:0]  w_g;
    logic [DAC_W-1:0]  w_b;

    // Next raster position; both counters return to 0 together at frame end.
    always_comb begin
        w_h_nx = r_h + HW'(1);
        w_v_nx = r_v;
        w_wrap = 1'b0;
        if (r_h == H_LAST) begin
            w_h_nx = '0;
            if (r_v == V_LAST) begin
                w_v_nx = '0;
                w_wrap = 1'b1;
            end else begin
                w_v_nx = r_v + VW'(1);
            end
        end
    end

    assign w_act_p0    = r_run && (r_h < H_ACT) && (r_v < V_ACT);
    assign w_hs_p0     = !(r_run && (r_h >= HS_BEG) && (r_h < HS_END));
    assign w_vs_p0     = !(r_run && (r_v >= VS_BEG) && (r_v < VS_END));
    assign w_tag_p0    = {r_mode_q, f_bar(r_h), w_vs_p0, w_hs_p0, w_act_p0};

    assign rd_en       = w_act_p0;
    assign rd_addr     = r_addr;
    assign frame_start = r_run && (r_h == '0) && (r_v == '0);
    assign line_start  = r_run && (r_h == '0) && (r_v < V_ACT);
    assign VGA_CLK     = ~c25;
    assign VGA_SYNC    = 1'b0;

    // Counter stage: first edge after reset parks at (0,0), then the raster runs.
    always_ff @(posedge c25 or negedge Reset) begin
        if (!Reset) begin
            r_run    <= 1'b0;
            r_h      <= '0;
            r_v      <= '0;
            r_addr   <= '0;
            r_mode_q <= 2'd0;
        end else if (!r_run) begin
            r_run    <= 1'b1;
            r_addr   <= '0;
            r_mode_q <= mode;
        end else begin
            r_h <= w_h_nx;
            r_v <= w_v_nx;
            if (w_wrap) begin
                r_addr   <= '0;
                r_mode_q <= mode;
            end else if (w_act_p0) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    generate
        if (RD_LAT == 0) begin : g_nodly
            assign w_tag_pn = w_tag_p0;
        end else begin : g_dly
            localparam int DLW = 8 * RD_LAT;
            logic [DLW-1:0] r_tag_dly;
            // Delay line matching the framebuffer read latency.
            always_ff @(posedge c25 or negedge Reset) begin
                if (!Reset) r_tag_dly <= {RD_LAT{TAG_RST}};
                else        r_tag_dly <= DLW'({r_tag_dly, w_tag_p0});
            end
            assign w_tag_pn = r_tag_dly[DLW-1 -: 8];
        end
    endgenerate

    // Pixel decode at the read-data stage; blanking forces black.
    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        case (w_tag_pn[7:6])
            2'd1: begin
                w_r = f_expand({3'd0, pixel_in[15:11]}, 5);
                w_g = f_expand({2'd0, pixel_in[10:5]}, 6);
                w_b = f_expand({3'd0, pixel_in[4:0]}, 5);
            end
            2'd2: begin
                w_r = {DAC_W{w_tag_pn[5]}};
                w_g = {DAC_W{w_tag_pn[4]}};
                w_b = {DAC_W{w_tag_pn[3]}};
            end
            default: begin
                w_r = f_expand({5'd0, pixel_in[7:5]}, 3);
                w_g = f_expand({5'd0, pixel_in[4:2]}, 3);
                w_b = f_expand({6'd0, pixel_in[1:0]}, 2);
            end
        endcase
        if (!w_tag_pn[0]) begin
            w_r = '0;
            w_g = '0;
            w_b = '0;
        end
    end

    // Output register driving the DAC pins.
    always_ff @(posedge c25 or negedge Reset) begin
        if (!Reset) begin
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            VGA_BLANK <= 1'b0;
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
        end else begin
            VGA_R     <= w_r;
            VGA_G     <= w_g;
            VGA_B     <= w_b;
            VGA_BLANK <= w_tag_pn[0];
            VGA_HS    <= w_tag_pn[1];
            VGA_VS    <= w_tag_pn[2];
        end
    end

endmodule

// File: tb/tb_vga_pixel_engine.sv
// tb_vga_pixel_engine: directed bench for vga_pixel_engine using a reduced
// raster (80x15 total, 64x8 visible) so several frames fit in a short run.
module tb_vga_pixel_engine;

    localparam int HA = 64, HF = 4, HSY = 8, HB = 4;
    localparam int VA = 8,  VF = 2, VSY = 2, VB = 3;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int DW = 10;
    localparam int LAT = 2;
    localparam int AW = 19;

    logic          c25;
    logic          Reset;
    logic [1:0]    mode;
    logic [15:0]   pixel_in;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          frame_start;
    logic          line_start;
    logic [DW-1:0] VGA_R, VGA_G, VGA_B;
    logic          VGA_CLK, VGA_BLANK, VGA_HS, VGA_VS, VGA_SYNC;

    logic          use_fb;
    logic [15:0]   pix_val;
    logic [AW-1:0] p1, p2;

    int n_chk;
    int n_fail;

    vga_pixel_engine #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .DAC_W(DW), .RD_LAT(LAT), .ADDR_W(AW)
    ) dut (
        .c25(c25), .Reset(Reset), .mode(mode), .pixel_in(pixel_in),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .frame_start(frame_start), .line_start(line_start),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_CLK(VGA_CLK), .VGA_BLANK(VGA_BLANK),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_SYNC(VGA_SYNC)
    );

    initial begin
        c25 = 1'b0;
        forever #5 c25 = ~c25;
    end

    // Framebuffer model: returns rd_addr[7:0] two cycles after the read.
    always @(posedge c25) begin
        p1 <= rd_addr;
        p2 <= p1;
    end

    always_comb pixel_in = use_fb ? {8'h00, p2[7:0]} : pix_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge c25);
        #1;
    endtask

    task automatic wait_addr(input string tag, input int a);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step();
            if (rd_en && rd_addr == AW'(a)) found = 1'b1;
        end
        if (!found) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_frame(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step();
            if (frame_start) found = 1'b1;
        end
        if (!found) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic chk_rgb(input string tag, input int r, input int g, input int b);
        chk({tag, "_R"}, 32'(VGA_R), r);
        chk({tag, "_G"}, 32'(VGA_G), g);
        chk({tag, "_B"}, 32'(VGA_B), b);
    endtask

    initial begin
        int hs_lo, vs_lo, bl_hi, rgb_bad, fs_n, ls_n, rise_i, fall_i, n;
        logic pb, ph;
        n_chk   = 0;
        n_fail  = 0;
        Reset   = 1'b0;
        mode    = 2'd0;
        use_fb  = 1'b1;
        pix_val = 16'h0000;

        // Reset values
        repeat (3) @(posedge c25);
        @(negedge c25);
        #1;
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_line_start", 32'(line_start), 0);
        chk_rgb("rst", 0, 0, 0);
        chk("rst_blank", 32'(VGA_BLANK), 0);
        chk("rst_hs", 32'(VGA_HS), 1);
        chk("rst_vs", 32'(VGA_VS), 1);
        chk("rst_sync", 32'(VGA_SYNC), 0);
        chk("vga_clk", 32'(VGA_CLK), 1);

        // Release: (0,0) appears on the first edge
        @(negedge c25);
        Reset = 1'b1;
        step();
        chk("rel_frame_start", 32'(frame_start), 1);
        chk("rel_line_start", 32'(line_start), 1);
        chk("rel_rd_en", 32'(rd_en), 1);
        chk("rel_rd_addr", 32'(rd_addr), 0);
        step();
        chk("rel_fs_drop", 32'(frame_start), 0);
        chk("rel_rd_addr1", 32'(rd_addr), 1);

        // Alignment in RGB332 with the framebuffer model
        wait_addr("to_addr49", 'h49);
        repeat (2) step();
        chk("lat2_B_still_prev", 32'(VGA_B), 0);
        step();
        chk_rgb("px49", 'h124, 'h124, 'h155);
        wait_addr("to_addrE0", 'hE0);
        repeat (3) step();
        chk_rgb("pxE0", 'h3FF, 0, 0);

        // One full frame of sync / blank accounting
        wait_frame("to_frame_sync");
        hs_lo = 0; vs_lo = 0; bl_hi = 0; rgb_bad = 0; fs_n = 0; ls_n = 0;
        rise_i = -1; fall_i = -1;
        pb = VGA_BLANK;
        ph = VGA_HS;
        for (int c = 0; c < HT * VT; c++) begin
            if (c > 0) step();
            if (!VGA_HS) hs_lo++;
            if (!VGA_VS) vs_lo++;
            if (VGA_BLANK) bl_hi++;
            if (!VGA_BLANK && (VGA_R != 0 || VGA_G != 0 || VGA_B != 0)) rgb_bad++;
            if (frame_start) fs_n++;
            if (line_start) ls_n++;
            if (rise_i < 0 && VGA_BLANK && !pb) rise_i = c;
            if (rise_i >= 0 && fall_i < 0 && !VGA_HS && ph) fall_i = c;
            pb = VGA_BLANK;
            ph = VGA_HS;
        end
        chk("hs_low_cycles", hs_lo, HSY * VT);
        chk("vs_low_cycles", vs_lo, VSY * HT);
        chk("blank_high_cycles", bl_hi, HA * VA);
        chk("rgb_in_blank", rgb_bad, 0);
        chk("frame_start_pulses", fs_n, 1);
        chk("line_start_pulses", ls_n, VA);
        chk("hs_offset", fall_i - rise_i, HA + HF);

        // RGB565 with a constant pixel
        mode    = 2'd1;
        use_fb  = 1'b0;
        pix_val = 16'hF800;
        wait_frame("to_frame_565");
        wait_addr("to_addr10", 10);
        repeat (3) step();
        chk_rgb("565_red", 'h3FF, 0, 0);
        pix_val = 16'h07E0;
        wait_addr("to_addr20", 20);
        repeat (3) step();
        chk_rgb("565_green", 0, 'h3FF, 0);
        pix_val = 16'h001F;
        wait_addr("to_addr30", 30);
        repeat (3) step();
        chk_rgb("565_blue", 0, 0, 'h3FF);
        pix_val = 16'h8410;
        wait_addr("to_addr40", 40);
        repeat (3) step();
        chk_rgb("565_mid", 'h210, 'h208, 'h210);

        // Mode switch mid-frame: current frame keeps framebuffer data
        mode   = 2'd0;
        use_fb = 1'b1;
        wait_frame("to_frame_sw");
        wait_addr("to_line4", 4 * HA);
        mode = 2'd2;
        wait_addr("to_addr265", 4 * HA + 9);
        repeat (3) step();
        chk_rgb("sw_same_frame", 0, 'h124, 'h155);
        wait_frame("to_frame_bars");
        wait_addr("to_bar1", 8);
        repeat (3) step();
        chk_rgb("bar1", 0, 0, 'h3FF);
        wait_addr("to_bar5", 40);
        repeat (3) step();
        chk_rgb("bar5", 'h3FF, 0, 'h3FF);

        // Reserved mode behaves as RGB332
        mode = 2'd3;
        wait_frame("to_frame_m3");
        wait_addr("to_m3_49", 'h49);
        repeat (3) step();
        chk_rgb("mode3_px49", 'h124, 'h124, 'h155);

        // Asynchronous reset mid-frame at line 5
        wait_addr("to_line5", 5 * HA + 10);
        #2;
        Reset = 1'b0;
        #1;
        chk("mid_rst_rd_en", 32'(rd_en), 0);
        chk("mid_rst_rd_addr", 32'(rd_addr), 0);
        chk_rgb("mid_rst", 0, 0, 0);
        chk("mid_rst_blank", 32'(VGA_BLANK), 0);
        chk("mid_rst_hs", 32'(VGA_HS), 1);
        chk("mid_rst_vs", 32'(VGA_VS), 1);
        repeat (3) @(negedge c25);
        Reset = 1'b1;
        step();
        chk("restart_frame_start", 32'(frame_start), 1);
        chk("restart_rd_addr", 32'(rd_addr), 0);
        n = 0;
        while (VGA_VS && n < 3000) begin
            step();
            n++;
        end
        chk("restart_vs_delay", n, (VA + VF) * HT + LAT + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
